// File: rtl/dmem_port_arbiter.sv
// Two-port (core C / aux A) arbiter in front of a single-port data memory; build option CORE_PRIORITY_EN.
// Latency: ISSUE one cycle after the request is sampled; write done +1, read done +1+RD_LAT after ISSUE.
// Backpressure: req is only sampled in IDLE, one access is in flight at a time, and there is no preemption.
module dmem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // The wait counter runs 0..RD_LAT-1; RD_LAT is at most 4, so two bits are enough.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        wait_cnt;
    logic              grant;
    logic              grant_port;

    // Next-state logic and arbitration. Requests are only looked at in IDLE.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                if (c_req || a_req) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                    if (c_req && a_req) begin
`ifdef CORE_PRIORITY_EN
                        grant_port = 1'b0;
`else
                        grant_port = ~last_owner;
`endif
                    end else begin
                        grant_port = a_req;
                    end
                end
            end
            ISSUE:   state_nxt = lat_we ? RESP : WAIT;
            WAIT:    if (wait_cnt == LAST_CNT) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latch the winner's command and record ownership at grant time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (grant) begin
            owner      <= grant_port;
            last_owner <= grant_port;
            lat_we     <= grant_port ? a_we    : c_we;
            lat_addr   <= grant_port ? a_addr  : c_addr;
            lat_wdata  <= grant_port ? a_wdata : c_wdata;
        end
    end

    // Count read-latency cycles while waiting for the memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                wait_cnt <= '0;
        else if (state != WAIT)   wait_cnt <= '0;
        else if (wait_cnt != LAST_CNT) wait_cnt <= wait_cnt + 2'd1;
    end

    // Capture read data into the winner's register at the end of the last WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rdata <= '0;
            a_rdata <= '0;
        end else if (state == WAIT && wait_cnt == LAST_CNT) begin
            if (owner) a_rdata <= mem_rd_data;
            else       c_rdata <= mem_rd_data;
        end
    end

    assign c_gnt       = (state == ISSUE) && !owner;
    assign a_gnt       = (state == ISSUE) &&  owner;
    assign c_done      = (state == RESP)  && !owner;
    assign a_done      = (state == RESP)  &&  owner;
    assign mem_wr      = (state == ISSUE) &&  lat_we;
    assign mem_rd      = (state == ISSUE) && !lat_we;
    assign mem_addr    = lat_addr;
    assign mem_wr_data = lat_wdata;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance u_dut with RD_LAT=1, instance u_dut3 with RD_LAT=3.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Each comparison is an immediate assertion that counts failures.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;

    // RD_LAT = 1 instance
    logic        c_req = 0, c_we = 0, a_req = 0, a_we = 0;
    logic [8:0]  c_addr = '0, a_addr = '0;
    logic [31:0] c_wdata = '0, a_wdata = '0, mem_rd_data = '0;
    logic        c_gnt, c_done, a_gnt, a_done, mem_wr, mem_rd, busy, owner;
    logic [31:0] c_rdata, a_rdata, mem_wr_data;
    logic [8:0]  mem_addr;

    // RD_LAT = 3 instance
    logic        d_c_req = 0, d_c_we = 0, d_a_req = 0, d_a_we = 0;
    logic [8:0]  d_c_addr = '0, d_a_addr = '0;
    logic [31:0] d_c_wdata = '0, d_a_wdata = '0, d_mem_rd_data = '0;
    logic        d_c_gnt, d_c_done, d_a_gnt, d_a_done, d_mem_wr, d_mem_rd, d_busy, d_owner;
    logic [31:0] d_c_rdata, d_a_rdata, d_mem_wr_data;
    logic [8:0]  d_mem_addr;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .owner(owner)
    );

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .c_req(d_c_req), .c_we(d_c_we), .c_addr(d_c_addr), .c_wdata(d_c_wdata),
        .c_gnt(d_c_gnt), .c_done(d_c_done), .c_rdata(d_c_rdata),
        .a_req(d_a_req), .a_we(d_a_we), .a_addr(d_a_addr), .a_wdata(d_a_wdata),
        .a_gnt(d_a_gnt), .a_done(d_a_done), .a_rdata(d_a_rdata),
        .mem_wr(d_mem_wr), .mem_rd(d_mem_rd), .mem_addr(d_mem_addr),
        .mem_wr_data(d_mem_wr_data), .mem_rd_data(d_mem_rd_data),
        .busy(d_busy), .owner(d_owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       exp_aux;
        logic [8:0] exp_addr;

        // Reset state
        tick();
        tick();
        check("rst_c_gnt", c_gnt, 0);
        check("rst_a_done", a_done, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_a_rdata", a_rdata, 0);
        reset = 1'b0;

        // 1: core write 0x010 <- DEADBEEF
        c_req = 1; c_we = 1; c_addr = 9'h010; c_wdata = 32'hDEADBEEF;
        tick();
        check("t1_mem_wr", mem_wr, 1);
        check("t1_mem_rd", mem_rd, 0);
        check("t1_mem_addr", mem_addr, 32'h010);
        check("t1_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
        check("t1_c_gnt", c_gnt, 1);
        check("t1_a_gnt", a_gnt, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_c_done", c_done, 1);
        check("t1_a_done", a_done, 0);
        check("t1_mem_wr_off", mem_wr, 0);
        c_req = 0;
        tick();
        check("t1_idle_done", c_done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_addr_hold", mem_addr, 32'h010);

        // 2: aux read 0x1FF, memory returns 12345678 in the WAIT cycle
        a_req = 1; a_we = 0; a_addr = 9'h1FF; mem_rd_data = 32'hBAD0BAD0;
        tick();
        check("t2_mem_rd", mem_rd, 1);
        check("t2_mem_wr", mem_wr, 0);
        check("t2_mem_addr", mem_addr, 32'h1FF);
        check("t2_a_gnt", a_gnt, 1);
        check("t2_owner", owner, 1);
        mem_rd_data = 32'h12345678;
        tick();
        check("t2_mem_rd_off", mem_rd, 0);
        check("t2_wait_done", a_done, 0);
        tick();
        check("t2_a_done", a_done, 1);
        check("t2_a_rdata", a_rdata, 32'h12345678);
        a_req = 0; mem_rd_data = 32'h0;
        tick();
        check("t2_done_off", a_done, 0);
        check("t2_a_rdata_hold", a_rdata, 32'h12345678);
        check("t2_c_rdata", c_rdata, 0);

        // 3/4: both ports write continuously; last owner was aux
        c_req = 1; c_we = 1; c_addr = 9'h020; c_wdata = 32'h11111111;
        a_req = 1; a_we = 1; a_addr = 9'h030; a_wdata = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
`ifdef CORE_PRIORITY_EN
            exp_aux = 1'b0;
`else
            exp_aux = (k % 2) == 1;
`endif
            exp_addr = exp_aux ? 9'h030 : 9'h020;
            tick();
            check("t3_c_gnt", c_gnt, !exp_aux);
            check("t3_a_gnt", a_gnt, exp_aux);
            check("t3_mem_addr", mem_addr, exp_addr);
            check("t3_mem_wr_data", mem_wr_data, exp_aux ? 32'h22222222 : 32'h11111111);
            tick();
            check("t3_c_done", c_done, !exp_aux);
            check("t3_a_done", a_done, exp_aux);
            if (k == 3) begin
                c_req = 0;
                a_req = 0;
            end
            tick();
            check("t3_idle_busy", busy, 0);
        end
        tick();
        check("t3_stop_busy", busy, 0);

        // 5: reset during WAIT of a core read
        c_req = 1; c_we = 0; c_addr = 9'h044;
        tick();
        check("t5_issue_rd", mem_rd, 1);
        tick();
        check("t5_wait_busy", busy, 1);
        #1 reset = 1'b1;
        mem_rd_data = 32'hFFFF0000;
        c_req = 0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_owner", owner, 0);
        check("t5_rst_c_gnt", c_gnt, 0);
        tick();
        check("t5_no_c_done", c_done, 0);
        check("t5_c_rdata", c_rdata, 0);
        reset = 1'b0;
        a_req = 1; a_we = 1; a_addr = 9'h0AB; a_wdata = 32'h5A5A5A5A;
        tick();
        check("t5_a_gnt", a_gnt, 1);
        check("t5_mem_wr", mem_wr, 1);
        check("t5_mem_addr", mem_addr, 32'h0AB);
        tick();
        check("t5_a_done", a_done, 1);
        a_req = 0;
        tick();
        check("t5_idle", busy, 0);

        // 6: RD_LAT=3 core read 0x055, data valid only in the third WAIT cycle
        d_c_req = 1; d_c_we = 0; d_c_addr = 9'h055; d_mem_rd_data = 32'h0BADF00D;
        tick();
        check("t6_c_gnt", d_c_gnt, 1);
        check("t6_mem_rd", d_mem_rd, 1);
        check("t6_mem_addr", d_mem_addr, 32'h055);
        tick();
        check("t6_w1_done", d_c_done, 0);
        tick();
        check("t6_w2_done", d_c_done, 0);
        tick();
        check("t6_w3_done", d_c_done, 0);
        d_mem_rd_data = 32'hCAFEF00D;
        tick();
        check("t6_c_done", d_c_done, 1);
        check("t6_c_rdata", d_c_rdata, 32'hCAFEF00D);
        d_mem_rd_data = 32'h0BADF00D;
        d_c_req = 0;
        tick();
        check("t6_done_off", d_c_done, 0);
        check("t6_rdata_hold", d_c_rdata, 32'hCAFEF00D);
        check("t6_a_rdata", d_a_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
